// File: rtl/mac_dot_sequencer.sv
// Dot-product job controller around a DW x DW multiply-accumulate datapath.
// Takes a start/len command, consumes len operand beats, then presents the sum.
module mac_dot_sequencer #(
    parameter int DW = 4,
    parameter int AW = 12,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          abort,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_acc,
    output logic          out_ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic [LW-1:0]   count_q, count_d;
    logic [LW-1:0]   len_q, len_d;

    logic [2*DW-1:0] prod;
    logic [AW:0]     sum;
    logic [LW-1:0]   count_inc;

    assign prod      = {{DW{1'b0}}, in_a} * {{DW{1'b0}}, in_b};
    assign sum       = {1'b0, acc_q} + {{(AW+1-2*DW){1'b0}}, prod};
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        len_d   = len_q;
        if (abort) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        count_d = '0;
                        len_d   = len;
                        state_d = (len != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        acc_d   = sum[AW-1:0];
                        ovf_d   = ovf_q | sum[AW];
                        count_d = count_inc;
                        if (count_inc == len_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // A new job may launch on the same cycle the result is taken.
                    if (out_ready) begin
                        if (start) begin
                            acc_d   = '0;
                            ovf_d   = 1'b0;
                            count_d = '0;
                            len_d   = len;
                            state_d = (len != '0) ? ST_RUN : ST_DONE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer: a 12-bit and an 8-bit accumulator
// instance share stimulus; expected sums are queued at job start.
module tb_mac_dot_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        abort;
    logic        in_valid;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic        out_ready;

    logic        busy, in_ready, out_valid, out_ovf;
    logic [11:0] out_acc;
    logic        busy8, in_ready8, out_valid8, out_ovf8;
    logic [7:0]  out_acc8;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned sb_q[$];
    logic [3:0]  pa[15];
    logic [3:0]  pb[15];

    mac_dot_sequencer #(.DW(4), .AW(12), .LW(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf)
    );

    mac_dot_sequencer #(.DW(4), .AW(8), .LW(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .busy(busy8), .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a),
        .in_b(in_b), .out_valid(out_valid8), .out_ready(out_ready),
        .out_acc(out_acc8), .out_ovf(out_ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result handshakes are scored mid-cycle, ahead of the edge that consumes them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                int unsigned t;
                t = sb_q.pop_front();
                check("acc12", out_acc, t % 4096);
                check("ovf12", out_ovf, (t >= 4096) ? 1 : 0);
                check("valid8", out_valid8, 1);
                check("acc8", out_acc8, t % 256);
                check("ovf8", out_ovf8, (t >= 256) ? 1 : 0);
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_acc"}, out_acc, 0);
    endtask

    task automatic run_job(input int L, input logic [7:0] vpat, input int vper, input int stall);
        int unsigned total;
        int idx;
        int cyc;
        total = 0;
        for (int i = 0; i < L; i++) total += int'(pa[i]) * int'(pb[i]);
        sb_q.push_back(total);
        start = 1'b1;
        len   = 4'(L);
        step();
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < L && cyc < 64) begin
            check("in_ready_run", in_ready, 1);
            check("out_valid_run", out_valid, 0);
            in_valid = vpat[cyc % vper];
            in_a = pa[idx];
            in_b = pb[idx];
            step();
            if (in_valid) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check("beat_budget", idx, L);
        check("done_latency", out_valid, 1);
        check("done_in_ready", in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", out_valid, 1);
            check("stall_acc", out_acc, total % 4096);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        #13;
        check_idle("reset");
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check_idle("idle");
        end

        // basic job: 15 + 225 + 14 = 254
        pa[0] = 4'd3;  pb[0] = 4'd5;
        pa[1] = 4'd15; pb[1] = 4'd15;
        pa[2] = 4'd2;  pb[2] = 4'd7;
        run_job(3, 8'hFF, 1, 0);

        // in_valid pattern 1,0,0,1,0,1 and 4 stalled result cycles
        run_job(3, 8'b0010_1001, 6, 4);

        // 15 x 225 = 3375: fits 12 bits, wraps 8 bits to 47
        for (int i = 0; i < 15; i++) begin
            pa[i] = 4'd15;
            pb[i] = 4'd15;
        end
        run_job(15, 8'hFF, 1, 1);

        // len=0 then back-to-back job launched on the handshake
        sb_q.push_back(0);
        start = 1'b1;
        len   = 4'd0;
        step();
        start = 1'b0;
        check("len0_valid", out_valid, 1);
        check("len0_acc", out_acc, 0);
        sb_q.push_back(16);
        out_ready = 1'b1;
        start = 1'b1;
        len   = 4'd1;
        step();
        out_ready = 1'b0;
        start = 1'b0;
        check("b2b_in_ready", in_ready, 1);
        check("b2b_acc_cleared", out_acc, 0);
        in_valid = 1'b1; in_a = 4'd4; in_b = 4'd4;
        step();
        in_valid = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_acc", out_acc, 16);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b_idle", busy, 0);

        // abort after two beats
        start = 1'b1;
        len   = 4'd5;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3;
        step();
        step();
        check("pre_abort_acc", out_acc, 18);
        abort = 1'b1;
        out_ready = 1'b1;
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        check_idle("abort");
        for (int c = 0; c < 3; c++) begin
            step();
            check("abort_no_valid", out_valid, 0);
        end
        out_ready = 1'b0;
        pa[0] = 4'd1; pb[0] = 4'd1;
        run_job(1, 8'hFF, 1, 0);

        // reset pulsed mid-RUN
        start = 1'b1;
        len   = 4'd5;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_ovf", out_ovf, 0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_idle("post_reset");

        pa[0] = 4'd9; pb[0] = 4'd7;
        pa[1] = 4'd8; pb[1] = 4'd6;
        run_job(2, 8'hFF, 1, 2);

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Job controller for the 4-bit multiply-accumulate datapath. It accepts a "start" command with a term count, then accepts exactly that many operand pairs over a valid/ready stream. Each accepted pair is multiplied and added to a cleared accumulator. The final sum is presented on a valid/ready result port. It sits between an operand source (buffer or upstream FSM) and the consumer of dot-product results. It adds the clear, enable, count and handshake sequencing that the bare free-running MAC lacks.

## Interface
- DW, 4 — operand width (unsigned).
- AW, 12 — accumulator/result width; must be ≥ 2·DW.
- LW, 4 — term-count width; max job length 2^LW−1.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  job request; sampled as described under Operation.
- len  input  LW  number of terms for the job; sampled with start.
- abort  input  1  synchronous abort; returns FSM to IDLE.
- busy  output  1  high in RUN and DONE.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  high only in RUN.
- in_a  input  DW  multiplicand.
- in_b  input  DW  multiplier.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_acc  output  AW  accumulated sum.
- out_ovf  output  1  sticky: accumulator wrapped during this job.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: acc=0, count=0, ovf=0, busy=0, in_ready=0, out_valid=0.
- IDLE, start=1:
  - Clear acc and ovf; latch len; count=0.
  - len≠0 → RUN. len=0 → DONE with acc=0, ovf=0.
- IDLE, start=0: no change.
- RUN:
  - in_ready=1. A beat is in_valid & in_ready.
  - On each beat: acc ← (acc + in_a·in_b) mod 2^AW, and count ← count+1.
  - The product is exact, 2·DW bits, zero-extended to AW.
  - ovf is set if the (AW+1)-bit sum has bit AW set; it stays set for the job.
  - On the beat where count+1 == latched len → DONE.
  - in_valid=0: hold state; no accumulation.
- DONE:
  - out_valid=1. out_acc and out_ovf are stable until handshake.
  - Handshake (out_valid & out_ready) with start=0 → IDLE.
  - Handshake with start=1: new job accepted in the same cycle, exactly as from IDLE (clear, latch len) → RUN, or → DONE if len=0.
  - No handshake: remain in DONE; start is ignored.
- start is ignored in RUN; len is not re-sampled.
- abort is highest priority in every state: next state IDLE, in_ready and out_valid deassert, no beat or result is consumed that cycle, and acc/ovf/count are cleared.
- Reset asserted mid-job: immediate return to IDLE with all reset values; no partial result is emitted.
- in_a/in_b are don't-care when no beat occurs.

## Timing
- All registers update on posedge clk; rst_n acts asynchronously.
- Start accepted at edge N → in_ready high from cycle N+1.
- Last beat at edge M → out_valid high in cycle M+1, with out_acc including that beat.
- Job of L terms with in_valid held high: 1 start cycle, L beats, then ≥1 DONE cycle.
- Back-to-back jobs lose no cycles: start can coincide with the result handshake.
- in_ready and out_valid are registered-state decodes; they are not combinationally dependent on in_valid or out_ready.
- out_acc is driven directly from the accumulator register.

## Test plan
- Reset then idle:
  - Stimulus: rst_n low, release; start=0 for 5 cycles.
  - Required: in_ready=0, out_valid=0, busy=0, out_acc=0 throughout.
- Basic job:
  - Stimulus: start, len=3; pairs (3,5),(15,15),(2,7), in_valid continuous.
  - Required: out_valid exactly 1 cycle after the 3rd beat; out_acc=254; out_ovf=0.
- Backpressure on both sides:
  - Stimulus: same job with in_valid toggled 1,0,0,1,0,1; out_ready held low 4 cycles.
  - Required: out_acc=254, held stable through the 4 stalled cycles; no extra beats counted.
- Overflow:
  - Stimulus: len=15, all pairs (15,15).
  - Required: out_acc = 3375 mod 4096 = 3375, out_ovf=0.
  - Then, with AW=8: out_acc = 3375 mod 256 = 47, out_ovf=1.
- len=0 and back-to-back:
  - Stimulus: start,len=0.
  - Required: DONE next cycle with out_acc=0.
  - Stimulus: during that handshake, start,len=1 with pair (4,4).
  - Required: second result 16, with no idle cycle between jobs.
- Abort and reset mid-job:
  - Stimulus: len=5, abort after 2 beats.
  - Required: IDLE next cycle, out_valid never asserts; a following job (len=1, pair (1,1)) returns 1.
  - Stimulus: rst_n pulsed low mid-RUN.
  - Required: outputs return to reset values immediately.
